// File: rtl/vend_pkg.sv
// Shared state encoding and display-selector codes for the vending controller.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CONFIG    = 3'd1,
    ST_SALE      = 3'd2,
    ST_DISPENSE  = 3'd3,
    ST_FLASH     = 3'd4,
    ST_DISPENSE2 = 3'd5,
    ST_CHANGE    = 3'd6
  } vend_state_e;

  localparam logic [2:0] DISP_IDLE   = 3'b001;
  localparam logic [2:0] DISP_CFG    = 3'b010;
  localparam logic [2:0] DISP_SALE   = 3'b011;
  localparam logic [2:0] DISP_CHANGE = 3'b100;
  localparam logic [2:0] DISP_VEND   = 3'b101;
  localparam logic [2:0] DISP_FLASH  = 3'b110;

  function automatic logic is_timed(input vend_state_e s);
    return (s == ST_DISPENSE) || (s == ST_FLASH) || (s == ST_DISPENSE2);
  endfunction

endpackage

// File: rtl/vend_phase_timer.sv
// Phase counter: clr forces zero, tc flags the last cycle (count DISP_CYCLES-1) of a phase.
module vend_phase_timer #(
  parameter int DISP_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tc
);

  localparam int TW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr ? '0 : cnt_q + TW'(1);
  end

  assign tc = (cnt_q == TW'(DISP_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vend_ctrl_fsm.sv
// Vending controller: config, coin credit, timed dispense/flash, change.
// Change return (change_valid/change_amt, credit clear) only when VEND_CHANGE_EN is defined.
module vend_ctrl_fsm
  import vend_pkg::*;
#(
  parameter int N_ITEMS     = 4,
  parameter int CREDIT_W    = 8,
  parameter int DISP_CYCLES = 1000,
  parameter int DEF_PRICE   = 50,
  localparam int IW         = $clog2(N_ITEMS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_mode,
  input  logic                cancel,
  input  logic [IW-1:0]       item_sel,
  input  logic                price_we,
  input  logic [CREDIT_W-1:0] price_in,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_val,
  input  logic                vend_req,
  output logic [2:0]          disp_code,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] price_out,
  output logic                dispense_valid,
  output logic [IW-1:0]       dispense_item,
  output logic                coin_reject,
  output logic                vend_deny,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt
);

  vend_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] price_q [N_ITEMS];
  logic [IW-1:0]       item_q, item_d;
  logic                rej_q, rej_d;
  logic                deny_q, deny_d;
  logic                price_wr;
  logic                tmr_clr, tmr_tc;
  logic                sel_ok;
  logic [CREDIT_W-1:0] sel_price;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;

  // Non-existent products read as the maximum price and can never be bought.
  assign sel_ok    = (int'(item_sel) < N_ITEMS);
  assign sel_price = sel_ok ? price_q[item_sel] : '1;
  assign price_out = sel_price;
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_fits = ~coin_sum[CREDIT_W];

  vend_phase_timer #(
    .DISP_CYCLES(DISP_CYCLES)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(tmr_clr),
    .tc (tmr_tc)
  );

  // Coins are accepted only in IDLE (which starts a sale) and SALE; anywhere else they bounce.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    item_d   = item_q;
    rej_d    = 1'b0;
    deny_d   = 1'b0;
    price_wr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_mode) begin
          state_d = ST_CONFIG;
          rej_d   = coin_valid;
        end else if (coin_valid) begin
          state_d = ST_SALE;
          if (coin_fits) credit_d = coin_sum[CREDIT_W-1:0];
          else           rej_d    = 1'b1;
        end
      end
      ST_CONFIG: begin
        rej_d    = coin_valid;
        price_wr = price_we && sel_ok;
        if (cancel)         state_d = ST_IDLE;
        else if (!cfg_mode) state_d = ST_SALE;
      end
      ST_SALE: begin
        if (cancel) begin
          state_d = ST_CHANGE;
          rej_d   = coin_valid;
        end else if (coin_valid) begin
          if (coin_fits) credit_d = coin_sum[CREDIT_W-1:0];
          else           rej_d    = 1'b1;
        end else if (cfg_mode && (credit_q == '0)) begin
          state_d = ST_CONFIG;
        end else if (vend_req) begin
          if (sel_ok && (credit_q >= sel_price)) begin
            state_d  = ST_DISPENSE;
            credit_d = credit_q - sel_price;
            item_d   = item_sel;
          end else begin
            deny_d = 1'b1;
          end
        end
      end
      ST_DISPENSE: begin
        rej_d = coin_valid;
        if (tmr_tc) state_d = ST_FLASH;
      end
      ST_FLASH: begin
        rej_d = coin_valid;
        if (tmr_tc) state_d = ST_DISPENSE2;
      end
      ST_DISPENSE2: begin
        rej_d = coin_valid;
        if (tmr_tc) state_d = ST_CHANGE;
      end
      ST_CHANGE: begin
        rej_d   = coin_valid;
        state_d = ST_IDLE;
`ifdef VEND_CHANGE_EN
        credit_d = '0;
`endif
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
        item_d   = '0;
      end
    endcase
    tmr_clr = (state_d != state_q) || !is_timed(state_q);
  end

  always_comb begin
    disp_code      = DISP_IDLE;
    dispense_valid = 1'b0;
    change_valid   = 1'b0;
    change_amt     = '0;
    case (state_q)
      ST_IDLE:      disp_code = DISP_IDLE;
      ST_CONFIG:    disp_code = DISP_CFG;
      ST_SALE:      disp_code = DISP_SALE;
      ST_DISPENSE: begin
        disp_code      = DISP_VEND;
        dispense_valid = 1'b1;
      end
      ST_FLASH:     disp_code = DISP_FLASH;
      ST_DISPENSE2: begin
        disp_code      = DISP_VEND;
        dispense_valid = 1'b1;
      end
      ST_CHANGE: begin
        disp_code = DISP_CHANGE;
`ifdef VEND_CHANGE_EN
        change_valid = 1'b1;
        change_amt   = credit_q;
`endif
      end
      default:      disp_code = DISP_IDLE;
    endcase
  end

  assign credit        = credit_q;
  assign dispense_item = item_q;
  assign coin_reject   = rej_q;
  assign vend_deny     = deny_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      item_q   <= '0;
      rej_q    <= 1'b0;
      deny_q   <= 1'b0;
      for (int i = 0; i < N_ITEMS; i++) price_q[i] <= CREDIT_W'(DEF_PRICE);
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      item_q   <= item_d;
      rej_q    <= rej_d;
      deny_q   <= deny_d;
      if (price_wr) price_q[item_sel] <= price_in;
    end
  end

endmodule

// File: tb/tb_vend_ctrl_fsm.sv
// Bench for vend_ctrl_fsm: directed scenarios plus random traffic against a transaction-level model.
module tb_vend_ctrl_fsm;

  localparam int NI = 4;
  localparam int CW = 8;
  localparam int DC = 4;
  localparam int DP = 50;
`ifdef VEND_CHANGE_EN
  localparam bit CHG_EN = 1'b1;
`else
  localparam bit CHG_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_CFG = 1, M_SALE = 2, M_VEND = 3, M_CHG = 4;

  logic          clk = 1'b0;
  logic          rst, cfg_mode, cancel, price_we, coin_valid, vend_req;
  logic [1:0]    item_sel;
  logic [CW-1:0] price_in, coin_val;
  logic [2:0]    disp_code;
  logic [CW-1:0] credit, price_out, change_amt;
  logic          dispense_valid, coin_reject, vend_deny, change_valid;
  logic [1:0]    dispense_item;

  int n_chk = 0;
  int n_pass = 0;

  // Model: a purchase is one 3*DC-cycle "vend" episode; phase = elapsed / DC.
  int m_mode, m_el, m_credit, m_item;
  int m_price [NI];
  bit m_rej, m_deny;

  vend_ctrl_fsm #(
    .N_ITEMS(NI), .CREDIT_W(CW), .DISP_CYCLES(DC), .DEF_PRICE(DP)
  ) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cancel(cancel), .item_sel(item_sel),
    .price_we(price_we), .price_in(price_in), .coin_valid(coin_valid), .coin_val(coin_val),
    .vend_req(vend_req), .disp_code(disp_code), .credit(credit), .price_out(price_out),
    .dispense_valid(dispense_valid), .dispense_item(dispense_item), .coin_reject(coin_reject),
    .vend_deny(vend_deny), .change_valid(change_valid), .change_amt(change_amt)
  );

  always #5 clk = ~clk;

  task automatic clr_in();
    rst = 1'b0; cfg_mode = 1'b0; cancel = 1'b0; item_sel = 2'd0; price_we = 1'b0;
    price_in = '0; coin_valid = 1'b0; coin_val = '0; vend_req = 1'b0;
  endtask

  task automatic model_step();
    m_rej = 0;
    m_deny = 0;
    if (rst) begin
      m_mode = M_IDLE; m_el = 0; m_credit = 0; m_item = 0;
      for (int i = 0; i < NI; i++) m_price[i] = DP;
      return;
    end
    case (m_mode)
      M_IDLE:
        if (cfg_mode) begin m_mode = M_CFG; m_rej = coin_valid; end
        else if (coin_valid) begin
          m_mode = M_SALE;
          if (m_credit + int'(coin_val) <= 255) m_credit += int'(coin_val);
          else m_rej = 1;
        end
      M_CFG: begin
        m_rej = coin_valid;
        if (price_we) m_price[item_sel] = int'(price_in);
        if (cancel) m_mode = M_IDLE;
        else if (!cfg_mode) m_mode = M_SALE;
      end
      M_SALE:
        if (cancel) begin m_mode = M_CHG; m_rej = coin_valid; end
        else if (coin_valid) begin
          if (m_credit + int'(coin_val) <= 255) m_credit += int'(coin_val);
          else m_rej = 1;
        end else if (cfg_mode && m_credit == 0) m_mode = M_CFG;
        else if (vend_req) begin
          if (m_credit >= m_price[item_sel]) begin
            m_mode = M_VEND; m_el = 0;
            m_credit -= m_price[item_sel];
            m_item = int'(item_sel);
          end else m_deny = 1;
        end
      M_VEND: begin
        m_rej = coin_valid;
        m_el++;
        if (m_el == 3 * DC) m_mode = M_CHG;
      end
      default: begin
        m_rej = coin_valid;
        m_mode = M_IDLE;
        if (CHG_EN) m_credit = 0;
      end
    endcase
  endtask

  function automatic int exp_disp();
    case (m_mode)
      M_IDLE: return 1;
      M_CFG:  return 2;
      M_SALE: return 3;
      M_VEND: return (m_el / DC == 1) ? 6 : 5;
      default: return 4;
    endcase
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic goto_sale(input int sel, input int price, input bit wr);
    cfg_mode = 1'b1;
    tick();
    if (wr) begin
      price_we = 1'b1; item_sel = 2'(sel); price_in = 8'(price);
      tick();
      price_we = 1'b0;
    end
    cfg_mode = 1'b0;
    tick();
  endtask

  task automatic insert(input int v);
    coin_valid = 1'b1; coin_val = 8'(v);
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (disp_code !== 3'b001) $display("FAIL rst_disp: got %b want 001", disp_code); else n_pass++;
    n_chk++; if (credit !== 8'd0) $display("FAIL rst_credit: got %0d want 0", credit); else n_pass++;
    n_chk++; if ({dispense_valid, coin_reject, vend_deny, change_valid} !== 4'b0)
      $display("FAIL rst_flags: got %b want 0000", {dispense_valid, coin_reject, vend_deny, change_valid});
    else n_pass++;
    n_chk++; if (change_amt !== 8'd0) $display("FAIL rst_chg_amt: got %0d want 0", change_amt); else n_pass++;
    n_chk++; if (dispense_item !== 2'd0) $display("FAIL rst_item: got %0d want 0", dispense_item); else n_pass++;
  endtask

  task automatic test_sale_dispense();
    do_reset();
    cfg_mode = 1'b1;
    tick();
    n_chk++; if (disp_code !== 3'b010) $display("FAIL cfg_disp: got %b want 010", disp_code); else n_pass++;
    price_we = 1'b1; item_sel = 2'd2; price_in = 8'd30;
    tick();
    price_we = 1'b0; cfg_mode = 1'b0;
    tick();
    n_chk++; if (disp_code !== 3'b011) $display("FAIL sale_disp: got %b want 011", disp_code); else n_pass++;
    n_chk++; if (price_out !== 8'd30) $display("FAIL price_wr: got %0d want 30", price_out); else n_pass++;
    insert(25);
    insert(10);
    n_chk++; if (credit !== 8'd35) $display("FAIL coin_sum: got %0d want 35", credit); else n_pass++;
    vend_req = 1'b1; item_sel = 2'd2;
    tick();
    vend_req = 1'b0;
    n_chk++; if (credit !== 8'd5) $display("FAIL vend_credit: got %0d want 5", credit); else n_pass++;
    n_chk++; if (dispense_item !== 2'd2) $display("FAIL vend_item: got %0d want 2", dispense_item); else n_pass++;
    for (int i = 0; i < 3 * DC; i++) begin
      n_chk++;
      if (dispense_valid !== (i / DC != 1) || disp_code !== ((i / DC == 1) ? 3'b110 : 3'b101))
        $display("FAIL vend_phase[%0d]: got dv=%b disp=%b", i, dispense_valid, disp_code);
      else n_pass++;
      tick();
    end
    n_chk++;
    if (change_valid !== CHG_EN || change_amt !== (CHG_EN ? 8'd5 : 8'd0) || disp_code !== 3'b100)
      $display("FAIL change: got cv=%b amt=%0d disp=%b want cv=%b", change_valid, change_amt, disp_code, CHG_EN);
    else n_pass++;
    tick();
    n_chk++;
    if (disp_code !== 3'b001 || change_valid !== 1'b0 || credit !== (CHG_EN ? 8'd0 : 8'd5))
      $display("FAIL after_change: got disp=%b cv=%b credit=%0d", disp_code, change_valid, credit);
    else n_pass++;
  endtask

  task automatic test_overflow_deny();
    do_reset();
    goto_sale(3, 255, 1'b1);
    insert(250);
    insert(10);
    n_chk++; if (coin_reject !== 1'b1 || credit !== 8'd250)
      $display("FAIL ovf_reject: got rej=%b credit=%0d want 1/250", coin_reject, credit);
    else n_pass++;
    tick();
    n_chk++; if (coin_reject !== 1'b0) $display("FAIL ovf_pulse: got %b want 0", coin_reject); else n_pass++;
    vend_req = 1'b1; item_sel = 2'd3;
    tick();
    vend_req = 1'b0;
    n_chk++; if (vend_deny !== 1'b1 || disp_code !== 3'b011 || credit !== 8'd250)
      $display("FAIL deny: got deny=%b disp=%b credit=%0d", vend_deny, disp_code, credit);
    else n_pass++;
    tick();
    n_chk++; if (vend_deny !== 1'b0) $display("FAIL deny_pulse: got %b want 0", vend_deny); else n_pass++;
  endtask

  task automatic test_coin_and_vend();
    do_reset();
    goto_sale(0, 0, 1'b0);
    insert(50);
    insert(10);
    coin_valid = 1'b1; coin_val = 8'd20; vend_req = 1'b1; item_sel = 2'd0;
    tick();
    coin_valid = 1'b0; vend_req = 1'b0;
    n_chk++;
    if (credit !== 8'd80 || disp_code !== 3'b011 || vend_deny !== 1'b0 || dispense_valid !== 1'b0)
      $display("FAIL coin_vend: got credit=%0d disp=%b deny=%b dv=%b", credit, disp_code, vend_deny, dispense_valid);
    else n_pass++;
  endtask

  task automatic test_cancel();
    do_reset();
    goto_sale(0, 0, 1'b0);
    insert(40);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n_chk++;
    if (disp_code !== 3'b100 || change_valid !== CHG_EN || change_amt !== (CHG_EN ? 8'd40 : 8'd0))
      $display("FAIL cancel_chg: got disp=%b cv=%b amt=%0d", disp_code, change_valid, change_amt);
    else n_pass++;
    tick();
    n_chk++;
    if (disp_code !== 3'b001 || credit !== (CHG_EN ? 8'd0 : 8'd40))
      $display("FAIL cancel_idle: got disp=%b credit=%0d", disp_code, credit);
    else n_pass++;
  endtask

  task automatic test_reset_mid_flash();
    do_reset();
    goto_sale(1, 70, 1'b1);
    insert(60);
    vend_req = 1'b1; item_sel = 2'd0;
    tick();
    vend_req = 1'b0;
    repeat (DC) tick();
    n_chk++; if (disp_code !== 3'b110 || dispense_valid !== 1'b0)
      $display("FAIL flash: got disp=%b dv=%b", disp_code, dispense_valid);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (disp_code !== 3'b001 || credit !== 8'd0 || dispense_valid !== 1'b0 || change_valid !== 1'b0)
      $display("FAIL flash_rst: got disp=%b credit=%0d dv=%b cv=%b", disp_code, credit, dispense_valid, change_valid);
    else n_pass++;
    for (int s = 0; s < NI; s++) begin
      item_sel = 2'(s);
      #1;
      n_chk++; if (price_out !== 8'd50) $display("FAIL rst_price[%0d]: got %0d want 50", s, price_out); else n_pass++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      n_chk++; if (disp_code !== 3'(exp_disp()))
        $display("FAIL rnd_disp c%0d: got %b want %0d", c, disp_code, exp_disp()); else n_pass++;
      n_chk++; if (credit !== 8'(m_credit))
        $display("FAIL rnd_credit c%0d: got %0d want %0d", c, credit, m_credit); else n_pass++;
      n_chk++; if (dispense_valid !== (m_mode == M_VEND && m_el / DC != 1))
        $display("FAIL rnd_dv c%0d: got %b", c, dispense_valid); else n_pass++;
      n_chk++; if (dispense_item !== 2'(m_item))
        $display("FAIL rnd_item c%0d: got %0d want %0d", c, dispense_item, m_item); else n_pass++;
      n_chk++; if (coin_reject !== m_rej)
        $display("FAIL rnd_rej c%0d: got %b want %b", c, coin_reject, m_rej); else n_pass++;
      n_chk++; if (vend_deny !== m_deny)
        $display("FAIL rnd_deny c%0d: got %b want %b", c, vend_deny, m_deny); else n_pass++;
      n_chk++; if (change_valid !== (m_mode == M_CHG && CHG_EN))
        $display("FAIL rnd_cv c%0d: got %b", c, change_valid); else n_pass++;
      n_chk++; if (change_amt !== ((m_mode == M_CHG && CHG_EN) ? 8'(m_credit) : 8'd0))
        $display("FAIL rnd_amt c%0d: got %0d", c, change_amt); else n_pass++;
      rst        = ($urandom_range(0, 499) == 0);
      cfg_mode   = ($urandom_range(0, 19) == 0);
      cancel     = ($urandom_range(0, 29) == 0);
      item_sel   = 2'($urandom_range(0, 3));
      price_we   = 1'($urandom_range(0, 1));
      price_in   = 8'($urandom_range(0, 150));
      coin_valid = ($urandom_range(0, 2) == 0);
      coin_val   = 8'($urandom_range(1, 120));
      vend_req   = ($urandom_range(0, 2) == 0);
      #1;
      n_chk++; if (price_out !== 8'(m_price[item_sel]))
        $display("FAIL rnd_price c%0d: got %0d want %0d", c, price_out, m_price[item_sel]); else n_pass++;
      tick();
    end
    clr_in();
  endtask

  initial begin
    clr_in();
    @(negedge clk);
    test_reset();
    test_sale_dispense();
    test_overflow_deny();
    test_coin_and_vend();
    test_cancel();
    test_reset_mid_flash();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
